// File: rtl/seven_seg_display_ctrl_pkg.sv
// Shared types, segment codes and the digit encoder for the HEX display controller.
package seven_seg_pkg;

    typedef logic [7:0] seg_code_t;

    // Active-low segment codes, bit7 = DP (always off)
    localparam seg_code_t SEG_0     = 8'hC0;
    localparam seg_code_t SEG_1     = 8'hF9;
    localparam seg_code_t SEG_2     = 8'hA4;
    localparam seg_code_t SEG_3     = 8'hB0;
    localparam seg_code_t SEG_4     = 8'h99;
    localparam seg_code_t SEG_5     = 8'h92;
    localparam seg_code_t SEG_6     = 8'h82;
    localparam seg_code_t SEG_7     = 8'hF8;
    localparam seg_code_t SEG_8     = 8'h80;
    localparam seg_code_t SEG_9     = 8'h90;
    localparam seg_code_t SEG_BLANK = 8'hFF;
    localparam seg_code_t SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } disp_state_e;

    function automatic seg_code_t bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// Value handshake and display outputs of the HEX display controller.
interface seven_seg_display_ctrl_if #(
    parameter int WIDTH      = 20,
    parameter int NUM_DIGITS = 6
);
    logic [WIDTH-1:0]        value_in;
    logic                    value_valid;
    logic                    value_ready;
    logic                    blank_en;
    logic [8*NUM_DIGITS-1:0] seg_out;
    logic                    overflow;
    logic                    update_pulse;

    modport master (
        output value_in, value_valid, blank_en,
        input  value_ready, seg_out, overflow, update_pulse
    );

    modport slave (
        input  value_in, value_valid, blank_en,
        output value_ready, seg_out, overflow, update_pulse
    );
endinterface

// File: rtl/seven_seg_display_ctrl_bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift step per cycle after i_start.
// o_done is high in the cycle whose rising edge performs the final shift.
module bin2bcd_serial #(
    parameter int WIDTH      = 20,
    parameter int BCD_DIGITS = (WIDTH + 2) / 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [WIDTH-1:0]        i_value,
    output logic [4*BCD_DIGITS-1:0] o_bcd,
    output logic                    o_done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic [WIDTH-1:0]        r_bin;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_adj;
    logic [CW-1:0]           r_cnt;

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_value;
            r_bcd <= '0;
            r_cnt <= CNT_INIT;
        end else if (r_cnt != '0) begin
            r_bcd <= {w_adj[4*BCD_DIGITS-2:0], r_bin[WIDTH-1]};
            r_bin <= {r_bin[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Binary-to-7-segment controller: handshake FSM, blanking/overflow encoding, output registers.
// Define SIGNED_DISPLAY_EN for two's-complement input with a sign digit in the top position.
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_seg_display_ctrl_if.slave bus
);
    localparam int unsigned BCD_DIGITS = (WIDTH + 2) / 3;
    localparam int unsigned EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
`ifdef SIGNED_DISPLAY_EN
    localparam int unsigned MAG_DIGITS = NUM_DIGITS - 1;
`else
    localparam int unsigned MAG_DIGITS = NUM_DIGITS;
`endif

    disp_state_e r_state, w_next;
    logic        w_accept;
    logic        w_ready;
    logic        w_done;
    logic        r_blank;
`ifdef SIGNED_DISPLAY_EN
    logic        r_neg;
`endif

    logic [WIDTH-1:0]        w_mag;
    logic [4*BCD_DIGITS-1:0] w_bcd;
    logic [4*EXT_DIGITS-1:0] w_bcd_ext;
    logic [3:0]              w_nib;
    logic                    w_seen;
    logic                    w_ovf;
    logic [8*NUM_DIGITS-1:0] w_seg;
    logic [8*NUM_DIGITS-1:0] r_seg;
    logic                    r_ovf;
    logic                    r_upd;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !reset;
                if (bus.value_valid && w_ready) begin
                    w_accept = 1'b1;
                    w_next   = SHIFT;
                end
            end
            SHIFT:   if (w_done) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef SIGNED_DISPLAY_EN
    always_comb w_mag = bus.value_in[WIDTH-1] ? ('0 - bus.value_in) : bus.value_in;
`else
    always_comb w_mag = bus.value_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blank <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
            r_neg   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_blank <= bus.blank_en;
`ifdef SIGNED_DISPLAY_EN
            r_neg   <= bus.value_in[WIDTH-1];
`endif
        end
    end

    bin2bcd_serial #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept),
        .i_value (w_mag),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    // Digits are scanned from most significant down so w_seen marks the first nonzero one
    always_comb begin
        w_bcd_ext                     = '0;
        w_bcd_ext[4*BCD_DIGITS-1:0]   = w_bcd;
        w_ovf                         = 1'b0;
        w_seen                        = 1'b0;
        w_nib                         = '0;
        w_seg                         = '0;
        for (int unsigned k = 0; k < EXT_DIGITS; k++) begin
            if (k >= MAG_DIGITS && w_bcd_ext[4*k +: 4] != 4'd0)
                w_ovf = 1'b1;
        end
        for (int unsigned k = 0; k < MAG_DIGITS; k++) begin
            w_nib = w_bcd_ext[4*(MAG_DIGITS-1-k) +: 4];
            if (w_nib != 4'd0)
                w_seen = 1'b1;
            if (r_blank && !w_seen && k != MAG_DIGITS - 1)
                w_seg[8*(MAG_DIGITS-1-k) +: 8] = SEG_BLANK;
            else
                w_seg[8*(MAG_DIGITS-1-k) +: 8] = bcd_to_seg(w_nib);
        end
`ifdef SIGNED_DISPLAY_EN
        w_seg[8*(NUM_DIGITS-1) +: 8] = r_neg ? SEG_DASH : SEG_BLANK;
`endif
        if (w_ovf)
            w_seg = {NUM_DIGITS{SEG_DASH}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= {NUM_DIGITS{SEG_0}};
            r_ovf <= 1'b0;
            r_upd <= 1'b0;
        end else begin
            r_upd <= (r_state == COMMIT);
            if (r_state == COMMIT) begin
                r_seg <= w_seg;
                r_ovf <= w_ovf;
            end
        end
    end

    assign bus.value_ready  = w_ready;
    assign bus.seg_out      = r_seg;
    assign bus.overflow     = r_ovf;
    assign bus.update_pulse = r_upd;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed scoreboard bench for seven_seg_display_ctrl (WIDTH=20, NUM_DIGITS=6).
module tb_seven_seg_display_ctrl;
    localparam int WIDTH = 20;
    localparam int ND    = 6;
    localparam logic [8*ND-1:0] ALL_ZERO = {ND{8'hC0}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seven_seg_display_ctrl_if #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) bus ();

    seven_seg_display_ctrl #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [8*ND-1:0] seg;
        logic            ovf;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int unsigned      e0       = 0;
    logic [8*ND-1:0]  last_seg;
    logic             last_ovf;
    logic [7:0]       codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                     8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference: decimal digits by division, not by double-dabble
    function automatic exp_t model(input logic [WIDTH-1:0] v, input logic bl);
        exp_t              e;
        longint unsigned   mag;
        longint unsigned   p;
        logic              neg;
        int                md;
`ifdef SIGNED_DISPLAY_EN
        neg = v[WIDTH-1];
        mag = neg ? ((64'd1 << WIDTH) - 64'(v)) : 64'(v);
        md  = ND - 1;
`else
        neg = 1'b0;
        mag = 64'(v);
        md  = ND;
`endif
        p = 1;
        for (int i = 0; i < md; i++) p = p * 10;
        e.ovf = (mag >= p);
        e.seg = '0;
        p = 1;
        for (int k = 0; k < ND; k++) begin
            if (e.ovf)                      e.seg[8*k +: 8] = 8'hBF;
            else if (k >= md)               e.seg[8*k +: 8] = neg ? 8'hBF : 8'hFF;
            else if (bl && k > 0 && mag < p) e.seg[8*k +: 8] = 8'hFF;
            else                            e.seg[8*k +: 8] = codes[int'((mag / p) % 10)];
            p = p * 10;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [WIDTH-1:0] v, input logic bl, input logic hold);
        logic got;
        sb.push_back(model(v, bl));
        bus.value_in    = v;
        bus.blank_en    = bl;
        bus.value_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.value_ready) got = 1'b1;
            tick();
        end
        check({tag, "_accept"}, 64'(got), 64'd1);
        e0 = cyc;
        if (!hold) begin
            bus.value_valid = 1'b0;
            bus.value_in    = ~v;
            bus.blank_en    = ~bl;
        end
    endtask

    task automatic wait_update(input string tag);
        exp_t e;
        logic seen;
        logic held;
        seen = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.update_pulse) seen = 1'b1;
            else if (bus.seg_out !== last_seg || bus.overflow !== last_ovf) held = 1'b0;
        end
        check({tag, "_pulse"}, 64'(bus.update_pulse), 64'd1);
        check({tag, "_latency"}, 64'(cyc - e0), 64'd21);
        check({tag, "_hold"}, 64'(held), 64'd1);
        e.seg = 'x;
        e.ovf = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, "_seg"}, 64'(bus.seg_out), 64'(e.seg));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
        last_seg = e.seg;
        last_ovf = e.ovf;
        tick();
        check({tag, "_pulse_width"}, 64'(bus.update_pulse), 64'd0);
    endtask

    initial begin
        logic quiet;
        bus.value_in    = '0;
        bus.value_valid = 1'b0;
        bus.blank_en    = 1'b0;
        reset           = 1'b1;

        tick();
        check("rst_ready", 64'(bus.value_ready), 64'd0);
        tick();
        tick();
        check("rst_seg", 64'(bus.seg_out), 64'(ALL_ZERO));
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        check("rst_pulse", 64'(bus.update_pulse), 64'd0);
        check("rst_ready_end", 64'(bus.value_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", 64'(bus.value_ready), 64'd1);
        last_seg = ALL_ZERO;
        last_ovf = 1'b0;

`ifdef SIGNED_DISPLAY_EN
        send("neg42", 20'hFFFD6, 1'b0, 1'b0);            wait_update("neg42");
        send("neg100k", 20'(-100000), 1'b0, 1'b0);       wait_update("neg100k");
        send("pos99999", 20'd99999, 1'b1, 1'b0);         wait_update("pos99999");
        send("neg99999", 20'(-99999), 1'b1, 1'b0);       wait_update("neg99999");
        send("zero", 20'd0, 1'b1, 1'b0);                 wait_update("zero");
`else
        send("v123456", 20'd123456, 1'b0, 1'b0);         wait_update("v123456");
        send("v42_blank", 20'd42, 1'b1, 1'b0);           wait_update("v42_blank");
        send("v0_blank", 20'd0, 1'b1, 1'b0);             wait_update("v0_blank");
        send("v1000000", 20'd1000000, 1'b0, 1'b0);       wait_update("v1000000");
        send("v7", 20'd7, 1'b0, 1'b0);                   wait_update("v7");
        send("v100_blank", 20'd100, 1'b1, 1'b0);         wait_update("v100_blank");
        send("v999999", 20'd999999, 1'b1, 1'b0);         wait_update("v999999");
        send("vmax", 20'hFFFFF, 1'b0, 1'b0);             wait_update("vmax");
`endif

        // value_valid held high: back-to-back conversions every WIDTH+2 cycles
        send("held1", 20'd5, 1'b0, 1'b1);
        sb.push_back(model(20'd5, 1'b0));
        wait_update("held1");
        e0 = cyc;
        check("held2_accept", 64'(bus.value_ready), 64'd0);
        wait_update("held2");
        check("held3_accept", 64'(bus.value_ready), 64'd0);
        bus.value_valid = 1'b0;

        // Reset five edges into the third conversion
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.update_pulse) quiet = 1'b0;
        end
        reset = 1'b1;
        tick();
        if (bus.update_pulse) quiet = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.update_pulse) quiet = 1'b0;
        end
        check("abort_no_pulse", 64'(quiet), 64'd1);
        check("abort_seg", 64'(bus.seg_out), 64'(ALL_ZERO));
        check("abort_ovf", 64'(bus.overflow), 64'd0);
        check("abort_ready", 64'(bus.value_ready), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
